// File: rtl/gshare_bpu_if.sv
// Fetch-side lookup and EX/MEM-side training bus of the gshare branch predictor.
// The slave modport is the predictor. The master modport is the pipeline that drives it.
interface gshare_bpu_if #(
  parameter int GHR_W = 8
);
  logic             ready;
  logic             lk_valid;
  logic [31:0]      lk_pc;
  logic             pred_valid;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic [GHR_W-1:0] pred_ghr;
  logic             upd_valid;
  logic [1:0]       upd_kind;
  logic [31:0]      upd_pc;
  logic [GHR_W-1:0] upd_ghr;
  logic             upd_taken;
  logic [31:0]      upd_target;
  logic             upd_mispredict;
  logic [31:0]      perf_lookups;
  logic [31:0]      perf_mispredicts;

  modport master (
    input  ready, pred_valid, pred_taken, pred_target, pred_ghr,
           perf_lookups, perf_mispredicts,
    output lk_valid, lk_pc, upd_valid, upd_kind, upd_pc, upd_ghr,
           upd_taken, upd_target, upd_mispredict
  );

  modport slave (
    output ready, pred_valid, pred_taken, pred_target, pred_ghr,
           perf_lookups, perf_mispredicts,
    input  lk_valid, lk_pc, upd_valid, upd_kind, upd_pc, upd_ghr,
           upd_taken, upd_target, upd_mispredict
  );
endinterface

// File: rtl/gshare_bpu.sv
// gshare predictor: a 2-bit counter PHT indexed by PC^GHR, a direct-mapped BTB, and a speculative GHR with mispredict recovery.
// Define BP_PERF_EN to build the lookup and mispredict performance counters. Without it, both counter ports read 0.
module gshare_bpu #(
  parameter int IDX_W     = 8,
  parameter int GHR_W     = 8,
  parameter int BTB_IDX_W = 6,
  parameter int TAG_W     = 10
) (
  input logic         clk,
  input logic         rst,
  gshare_bpu_if.slave bus
);
  localparam int PHT_DEPTH = 2**IDX_W;
  localparam int BTB_DEPTH = 2**BTB_IDX_W;
  localparam int PTR_W     = (IDX_W > BTB_IDX_W) ? IDX_W : BTB_IDX_W;
  localparam int TAG_LO    = BTB_IDX_W + 2;
  localparam int TAG_HI    = BTB_IDX_W + TAG_W + 1;
  localparam logic [1:0] KIND_COND = 2'b01;

  typedef enum logic {INIT, RUN} state_e;

  state_e           state_q;
  logic [PTR_W-1:0] ptr_q;
  logic             ready_q;
  logic             predValid_q;
  logic             predTaken_q;
  logic [31:0]      predTarget_q;
  logic [GHR_W-1:0] predGhr_q;
  logic [GHR_W-1:0] ghr_q, ghr_d;

  logic [1:0]       pht_q       [PHT_DEPTH];
  logic             btbValid_q  [BTB_DEPTH];
  logic [TAG_W-1:0] btbTag_q    [BTB_DEPTH];
  logic [31:0]      btbTarget_q [BTB_DEPTH];
  logic [1:0]       btbKind_q   [BTB_DEPTH];

  logic [IDX_W-1:0]     lkIdx, updIdx;
  logic [BTB_IDX_W-1:0] lkBtbIdx, updBtbIdx;
  logic                 lkHit, lkCond, predTaken_d;
  logic [31:0]          predTarget_d;
  logic                 lkFire, updFire;
  logic [1:0]           phtUpd_d;
  logic                 unusedPcBits;

  assign lkIdx     = bus.lk_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
  assign updIdx    = bus.upd_pc[IDX_W+1:2] ^ IDX_W'(bus.upd_ghr);
  assign lkBtbIdx  = bus.lk_pc[BTB_IDX_W+1:2];
  assign updBtbIdx = bus.upd_pc[BTB_IDX_W+1:2];
  assign lkFire    = (state_q == RUN) && bus.lk_valid;
  assign updFire   = (state_q == RUN) && bus.upd_valid && (bus.upd_kind != 2'b00);

  assign unusedPcBits = ^{bus.lk_pc[31:TAG_HI+1], bus.lk_pc[1:0],
                          bus.upd_pc[31:TAG_HI+1], bus.upd_pc[1:0]};

  // Tables are read combinationally from their current contents, so a same-cycle update is not yet visible.
  always_comb begin
    lkHit        = btbValid_q[lkBtbIdx] && (btbTag_q[lkBtbIdx] == bus.lk_pc[TAG_HI:TAG_LO]);
    lkCond       = lkHit && (btbKind_q[lkBtbIdx] == KIND_COND);
    predTaken_d  = lkCond ? pht_q[lkIdx][1] : lkHit;
    predTarget_d = predTaken_d ? btbTarget_q[lkBtbIdx] : bus.lk_pc + 32'd4;
  end

  always_comb begin
    phtUpd_d = pht_q[updIdx];
    if (bus.upd_taken && (pht_q[updIdx] != 2'b11)) begin
      phtUpd_d = pht_q[updIdx] + 2'b01;
    end else if (!bus.upd_taken && (pht_q[updIdx] != 2'b00)) begin
      phtUpd_d = pht_q[updIdx] - 2'b01;
    end
  end

  // A mispredict restores history from the resolved branch and overrides a speculative shift in the same cycle.
  always_comb begin
    ghr_d = ghr_q;
    if (lkFire && lkCond) begin
      ghr_d = {ghr_q[GHR_W-2:0], predTaken_d};
    end
    if (updFire && bus.upd_mispredict) begin
      ghr_d = (bus.upd_kind == KIND_COND) ? {bus.upd_ghr[GHR_W-2:0], bus.upd_taken}
                                          : bus.upd_ghr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT;
      ptr_q        <= '0;
      ready_q      <= 1'b0;
      predValid_q  <= 1'b0;
      predTaken_q  <= 1'b0;
      predTarget_q <= '0;
      predGhr_q    <= '0;
      ghr_q        <= '0;
    end else begin
      case (state_q)
        INIT: begin
          ptr_q       <= ptr_q + PTR_W'(1);
          predValid_q <= 1'b0;
          if (ptr_q == '1) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          ghr_q       <= ghr_d;
          predValid_q <= bus.lk_valid;
          if (bus.lk_valid) begin
            predTaken_q  <= predTaken_d;
            predTarget_q <= predTarget_d;
            predGhr_q    <= ghr_q;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // Table storage has no reset of its own. INIT sweeps it after every rst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT) begin
        if (32'(ptr_q) < PHT_DEPTH) pht_q[ptr_q[IDX_W-1:0]] <= 2'b01;
        if (32'(ptr_q) < BTB_DEPTH) btbValid_q[ptr_q[BTB_IDX_W-1:0]] <= 1'b0;
      end else if (updFire) begin
        if (bus.upd_kind == KIND_COND) pht_q[updIdx] <= phtUpd_d;
        if (bus.upd_taken) begin
          btbValid_q[updBtbIdx]  <= 1'b1;
          btbTag_q[updBtbIdx]    <= bus.upd_pc[TAG_HI:TAG_LO];
          btbTarget_q[updBtbIdx] <= bus.upd_target;
          btbKind_q[updBtbIdx]   <= bus.upd_kind;
        end
      end
    end
  end

  assign bus.ready       = ready_q;
  assign bus.pred_valid  = predValid_q;
  assign bus.pred_taken  = predTaken_q;
  assign bus.pred_target = predTarget_q;
  assign bus.pred_ghr    = predGhr_q;

`ifdef BP_PERF_EN
  logic [31:0] perfLookups_q, perfMispredicts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perfLookups_q     <= '0;
      perfMispredicts_q <= '0;
    end else if (state_q == RUN) begin
      if (bus.lk_valid) perfLookups_q <= perfLookups_q + 32'd1;
      if (bus.upd_valid && bus.upd_mispredict) perfMispredicts_q <= perfMispredicts_q + 32'd1;
    end
  end

  assign bus.perf_lookups     = perfLookups_q;
  assign bus.perf_mispredicts = perfMispredicts_q;
`else
  assign bus.perf_lookups     = '0;
  assign bus.perf_mispredicts = '0;
`endif
endmodule

// File: tb/tb_gshare_bpu.sv
// Scoreboard bench for gshare_bpu: a table-level predictor model queues expected predictions and a negedge monitor checks them.
// The perf counter expectations follow BP_PERF_EN.
module tb_gshare_bpu;
  localparam int IDX_W       = 8;
  localparam int GHR_W       = 8;
  localparam int BTB_IDX_W   = 6;
  localparam int TAG_W       = 10;
  localparam int PHT_N       = 1 << IDX_W;
  localparam int BTB_N       = 1 << BTB_IDX_W;
  localparam int TAG_N       = 1 << TAG_W;
  localparam int GHR_N       = 1 << GHR_W;
  localparam int INIT_CYCLES = (PHT_N > BTB_N) ? PHT_N : BTB_N;
`ifdef BP_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  gshare_bpu_if #(.GHR_W(GHR_W)) bus ();

  gshare_bpu #(
    .IDX_W(IDX_W), .GHR_W(GHR_W), .BTB_IDX_W(BTB_IDX_W), .TAG_W(TAG_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             taken;
    logic [31:0]      target;
    logic [GHR_W-1:0] ghr;
  } pred_t;

  pred_t expQ[$];
  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model state: counters 0..3, BTB entries, history as a plain integer.
  int          mPht[PHT_N];
  bit          mValid[BTB_N];
  int          mTag[BTB_N];
  logic [31:0] mTarget[BTB_N];
  int          mKind[BTB_N];
  int          mGhr;
  int          mLookups;
  int          mMisp;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic printSummary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
  endtask

  task automatic modelReset();
    for (int i = 0; i < PHT_N; i++) mPht[i] = 1;
    for (int i = 0; i < BTB_N; i++) mValid[i] = 1'b0;
    mGhr = 0;
    mLookups = 0;
    mMisp = 0;
  endtask

  task automatic driveInputs(input bit lkv, input logic [31:0] lpc, input bit uv, input logic [1:0] uk,
                             input logic [31:0] upc, input int ughr, input bit ut,
                             input logic [31:0] utgt, input bit um);
    bus.lk_valid       = lkv;
    bus.lk_pc          = lpc;
    bus.upd_valid      = uv;
    bus.upd_kind       = uk;
    bus.upd_pc         = upc;
    bus.upd_ghr        = GHR_W'(ughr);
    bus.upd_taken      = ut;
    bus.upd_target     = utgt;
    bus.upd_mispredict = um;
  endtask

  // One clock of stimulus. The model reads its tables before applying that cycle's training.
  task automatic applyStimulus(input bit lkv, input logic [31:0] lpc, input bit uv, input logic [1:0] uk,
                               input logic [31:0] upc, input int ughr, input bit ut,
                               input logic [31:0] utgt, input bit um);
    int    bi, ui, idx, newGhr;
    bit    hit, taken;
    pred_t p;
    @(posedge clk);
    #1;
    driveInputs(lkv, lpc, uv, uk, upc, ughr, ut, utgt, um);
    if (bus.ready === 1'b1) begin
      newGhr = mGhr;
      if (lkv) begin
        bi  = int'((lpc >> 2) % BTB_N);
        idx = int'((lpc >> 2) % PHT_N) ^ mGhr;
        hit = mValid[bi] && (mTag[bi] == int'((lpc >> (BTB_IDX_W + 2)) % TAG_N));
        if (!hit) taken = 1'b0;
        else if (mKind[bi] == 1) taken = (mPht[idx] >= 2);
        else taken = 1'b1;
        p.taken  = taken;
        p.target = taken ? mTarget[bi] : lpc + 32'd4;
        p.ghr    = GHR_W'(mGhr);
        expQ.push_back(p);
        mLookups++;
        if (hit && mKind[bi] == 1) newGhr = (mGhr * 2 + int'(taken)) % GHR_N;
      end
      if (uv && um) mMisp++;
      if (uv && uk != 2'b00) begin
        if (um) newGhr = (uk == 2'b01) ? (ughr * 2 + int'(ut)) % GHR_N : ughr;
        if (uk == 2'b01) begin
          ui = int'((upc >> 2) % PHT_N) ^ ughr;
          if (ut) mPht[ui] = (mPht[ui] == 3) ? 3 : mPht[ui] + 1;
          else    mPht[ui] = (mPht[ui] == 0) ? 0 : mPht[ui] - 1;
        end
        if (ut) begin
          bi          = int'((upc >> 2) % BTB_N);
          mValid[bi]  = 1'b1;
          mTag[bi]    = int'((upc >> (BTB_IDX_W + 2)) % TAG_N);
          mTarget[bi] = utgt;
          mKind[bi]   = int'(uk);
        end
      end
      mGhr = newGhr;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic lookup(input logic [31:0] pc);
    applyStimulus(1'b1, pc, 1'b0, 2'b00, 32'h0, 0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic train(input logic [1:0] kind, input logic [31:0] pc, input int ghr,
                       input bit taken, input logic [31:0] tgt, input bit misp);
    applyStimulus(1'b0, 32'h0, 1'b1, kind, pc, ghr, taken, tgt, misp);
  endtask

  // Drives junk traffic through reset and INIT; none of it may be accepted.
  task automatic doReset();
    int cycles;
    @(posedge clk);
    #1;
    rst = 1'b1;
    driveInputs(1'b1, 32'h40, 1'b1, 2'b10, 32'h40, GHR_N - 1, 1'b1, 32'h999, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetReady", 64'(bus.ready), 64'd0);
    checkOutput("resetPred", 64'({bus.pred_valid, bus.pred_taken, bus.pred_target, bus.pred_ghr}), 64'd0);
    checkOutput("resetPerf", {bus.perf_lookups, bus.perf_mispredicts}, 64'd0);
    rst = 1'b0;
    modelReset();
    cycles = 0;
    while (bus.ready !== 1'b1 && cycles < 4 * INIT_CYCLES) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    driveInputs(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 0, 1'b0, 32'h0, 1'b0);
    checkOutput("readyLatency", 64'(cycles), 64'(INIT_CYCLES));
    if (bus.ready !== 1'b1) begin
      $display("[TB] FAIL readyTimeout: ready=%b after %0d cycles, expected 1", bus.ready, cycles);
      printSummary();
      $fatal(1, "[TB] ready never asserted");
    end
    checkOutput("initPerf", {bus.perf_lookups, bus.perf_mispredicts}, 64'd0);
  endtask

  pred_t mon;
  always @(negedge clk) begin
    if (bus.pred_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL unexpectedPred: pred_valid=1 with no lookup outstanding, expected 0 (t=%0t)", $time);
      end else begin
        mon = expQ.pop_front();
        checkOutput("prediction",
                    64'({bus.pred_taken, bus.pred_target, bus.pred_ghr}),
                    64'({mon.taken, mon.target, mon.ghr}));
      end
    end
  end

  initial begin
    logic [31:0] pc, tgt;
    logic [1:0]  kind;
    bit          uv, lkv, misp;

    driveInputs(1'b0, 32'h0, 1'b0, 2'b00, 32'h0, 0, 1'b0, 32'h0, 1'b0);
    doReset();

    // Cold table, cond training, jal entry.
    lookup(32'h100);
    train(2'b01, 32'h200, 0, 1'b1, 32'h180, 1'b0);
    train(2'b01, 32'h200, 0, 1'b1, 32'h180, 1'b0);
    lookup(32'h200);
    lookup(32'h100);
    train(2'b10, 32'h40, 0, 1'b1, 32'h800, 1'b0);
    lookup(32'h40);
    lookup(32'h100);

    // Recovery wins over a same-cycle speculative shift: GHR 0x0F -> 0x06.
    train(2'b10, 32'h40, 'h0F, 1'b1, 32'h800, 1'b1);
    applyStimulus(1'b1, 32'h200, 1'b1, 2'b01, 32'h300, 'h03, 1'b0, 32'h0, 1'b1);
    lookup(32'h100);

    // Saturation and read-before-write on a single PHT entry.
    repeat (5) train(2'b01, 32'h504, 0, 1'b1, 32'h520, 1'b0);
    train(2'b10, 32'h40, 0, 1'b1, 32'h800, 1'b1);
    applyStimulus(1'b1, 32'h504, 1'b1, 2'b01, 32'h504, 0, 1'b0, 32'h0, 1'b0);
    train(2'b10, 32'h40, 0, 1'b1, 32'h800, 1'b1);
    applyStimulus(1'b1, 32'h504, 1'b1, 2'b01, 32'h504, 0, 1'b0, 32'h0, 1'b0);
    train(2'b10, 32'h40, 0, 1'b1, 32'h800, 1'b1);
    lookup(32'h504);

    // Random traffic over a small PC pool with aliasing BTB indices.
    for (int i = 0; i < 400; i++) begin
      pc   = ($urandom_range(0, 1) ? 32'h1100 : 32'h1000) + 32'($urandom_range(0, 15) << 2);
      tgt  = $urandom & 32'hFFFF_FFFC;
      kind = 2'($urandom_range(0, 3));
      lkv  = ($urandom_range(0, 3) != 0);
      uv   = $urandom_range(0, 1) == 1;
      misp = (kind != 2'b00) && ($urandom_range(0, 3) == 0);
      applyStimulus(lkv, ($urandom_range(0, 1) ? pc : 32'h1000 + 32'($urandom_range(0, 15) << 2)),
                    uv, kind, pc, int'($urandom_range(0, GHR_N - 1)), $urandom_range(0, 1) == 1, tgt, misp);
    end
    idle(3);
    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
    checkOutput("perfLookups", 64'(bus.perf_lookups), PERF ? 64'(mLookups) : 64'd0);
    checkOutput("perfMispredicts", 64'(bus.perf_mispredicts), PERF ? 64'(mMisp) : 64'd0);

    // Mid-run reset wipes the tables and counters, then exactly 10 lookups and 3 mispredicts.
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'h504, i < 3, 2'b01, 32'h600, i, 1'b0, 32'h0, i < 3);
    end
    idle(3);
    checkOutput("queueDrained2", 64'(expQ.size()), 64'd0);
    checkOutput("perfLookups10", 64'(bus.perf_lookups), PERF ? 64'd10 : 64'd0);
    checkOutput("perfMispredicts3", 64'(bus.perf_mispredicts), PERF ? 64'd3 : 64'd0);

    doReset();
    lookup(32'h200);
    idle(3);
    checkOutput("queueDrained3", 64'(expQ.size()), 64'd0);

    printSummary();
    $finish;
  end
endmodule
